// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end: default sizes, loader state
// encoding and the packed-bus slot offset helper.
package fft_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_N          = 16;
  localparam int INDEX_WIDTH        = $clog2(DEFAULT_N);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } loader_state_t;

  function automatic int unsigned slot_offset(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/fft_sample_loader.sv
// Packs a serial stream of complex samples into N-slot frame buses, hands each
// full frame to the bit-reversal stage and holds it until reorder_done.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  input  logic                         in_last,
  output logic [N*DATA_WIDTH-1:0]      frame_real,
  output logic [N*DATA_WIDTH-1:0]      frame_imag,
  output logic                         start_reorder,
  input  logic                         reorder_done,
  output logic                         frame_err,
  output logic [$clog2(N)-1:0]         fill_count,
  output logic [CNT_WIDTH-1:0]         frame_count
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_SLOT = IW'(N - 1);

  loader_state_t  state_reg, state_next;
  logic [IW-1:0]  fill_count_reg, fill_count_next;
  logic [CNT_WIDTH-1:0] frame_count_reg, frame_count_next;
  logic           frame_err_reg, frame_err_next;
  logic           take;

  logic signed [DATA_WIDTH-1:0] slot_real_reg [N];
  logic signed [DATA_WIDTH-1:0] slot_imag_reg [N];

  // Handshake outputs are pure state decode, so in_ready never depends on in_valid.
  assign in_ready      = (state_reg == FILL);
  assign start_reorder = (state_reg == ISSUE);
  assign take          = in_valid & in_ready;
  assign fill_count    = fill_count_reg;
  assign frame_count   = frame_count_reg;
  assign frame_err     = frame_err_reg;

  always_comb begin
    state_next       = state_reg;
    fill_count_next  = fill_count_reg;
    frame_count_next = frame_count_reg;
    frame_err_next   = 1'b0;
    unique case (state_reg)
      FILL: begin
        if (take) begin
          if (fill_count_reg == LAST_SLOT) begin
            // A full frame is issued even when in_last is missing; only flag it.
            state_next      = ISSUE;
            fill_count_next = '0;
            frame_err_next  = ~in_last;
          end else if (in_last) begin
            fill_count_next = '0;
            frame_err_next  = 1'b1;
          end else begin
            fill_count_next = fill_count_reg + IW'(1);
          end
        end
      end
      ISSUE: begin
        state_next       = WAIT;
        frame_count_next = frame_count_reg + CNT_WIDTH'(1);
      end
      WAIT: begin
        if (reorder_done) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= FILL;
      fill_count_reg  <= '0;
      frame_count_reg <= '0;
      frame_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fill_count_reg  <= fill_count_next;
      frame_count_reg <= frame_count_next;
      frame_err_reg   <= frame_err_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        slot_real_reg[k] <= '0;
        slot_imag_reg[k] <= '0;
      end
    end else if (take) begin
      slot_real_reg[fill_count_reg] <= in_real;
      slot_imag_reg[fill_count_reg] <= in_imag;
    end
  end

  always_comb begin
    frame_real = '0;
    frame_imag = '0;
    for (int k = 0; k < N; k++) begin
      frame_real[slot_offset(k, DATA_WIDTH) +: DATA_WIDTH] = slot_real_reg[k];
      frame_imag[slot_offset(k, DATA_WIDTH) +: DATA_WIDTH] = slot_imag_reg[k];
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed scenarios with random sample data, checked against a frame-level
// model of what the loader should present on its outputs.
module tb_fft_sample_loader;

  localparam int DW = 16;
  localparam int NS = 16;
  localparam int CW = 16;
  localparam int IW = $clog2(NS);

  logic clk = 1'b0;
  logic reset, in_valid, in_last, reorder_done;
  logic [DW-1:0] in_real, in_imag;
  logic in_ready, start_reorder, frame_err;
  logic [NS*DW-1:0] frame_real, frame_imag;
  logic [IW-1:0] fill_count;
  logic [CW-1:0] frame_count;

  int checks = 0;
  int errors = 0;
  int start_seen = 0;
  int err_seen = 0;

  // Reference model state
  int m_fill = 0;
  int m_count = 0;
  int m_starts = 0;
  int m_errs = 0;
  logic [NS*DW-1:0] exp_real = '0;
  logic [NS*DW-1:0] exp_imag = '0;

  fft_sample_loader #(.DATA_WIDTH(DW), .N(NS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .frame_real(frame_real), .frame_imag(frame_imag),
    .start_reorder(start_reorder), .reorder_done(reorder_done),
    .frame_err(frame_err), .fill_count(fill_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_reorder === 1'b1) start_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [NS*DW-1:0] obs, input logic [NS*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  // Offer one sample while the loader is filling; model applies the frame rules.
  task automatic push(input logic [DW-1:0] r, input logic [DW-1:0] i, input bit last);
    in_valid = 1'b1;
    in_real  = r;
    in_imag  = i;
    in_last  = last;
    exp_real[m_fill*DW +: DW] = r;
    exp_imag[m_fill*DW +: DW] = i;
    if (m_fill == NS - 1) begin
      m_fill = 0;
      m_count++;
      m_starts++;
      if (!last) m_errs++;
    end else if (last) begin
      m_fill = 0;
      m_errs++;
    end else begin
      m_fill++;
    end
    cycle();
    chk("fill_count", int'(fill_count), m_fill);
  endtask

  task automatic push_frame(input int last_idx);
    for (int k = 0; k < NS; k++)
      push(DW'($urandom), DW'($urandom), k == last_idx);
  endtask

  // Entered one cycle after the last accepted sample; leaves with the loader back in FILL.
  task automatic issue_and_release(input int hold);
    chk("start_pulse", int'(start_reorder), 1);
    chk("ready_issue", int'(in_ready), 0);
    chk_bus("frame_real_issue", frame_real, exp_real);
    chk_bus("frame_imag_issue", frame_imag, exp_imag);
    in_valid = 1'b1;
    in_real  = DW'($urandom);
    in_imag  = DW'($urandom);
    in_last  = 1'($urandom);
    cycle();
    chk("start_clear", int'(start_reorder), 0);
    chk("frame_count", int'(frame_count), m_count % (1 << CW));
    for (int c = 0; c < hold; c++) begin
      chk("ready_wait", int'(in_ready), 0);
      in_real = DW'($urandom);
      cycle();
    end
    chk("ready_wait_end", int'(in_ready), 0);
    chk_bus("frame_real_hold", frame_real, exp_real);
    chk_bus("frame_imag_hold", frame_imag, exp_imag);
    reorder_done = 1'b1;
    cycle();
    reorder_done = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("ready_back", int'(in_ready), 1);
    chk("starts_total", start_seen, m_starts);
    chk("errs_total", err_seen, m_errs);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(in_ready), 1);
    chk({tag, "_start"}, int'(start_reorder), 0);
    chk({tag, "_err"}, int'(frame_err), 0);
    chk({tag, "_fill"}, int'(fill_count), 0);
    chk({tag, "_count"}, int'(frame_count), 0);
    chk_bus({tag, "_real"}, frame_real, '0);
    chk_bus({tag, "_imag"}, frame_imag, '0);
  endtask

  task automatic model_reset();
    m_fill = 0;
    m_count = 0;
    exp_real = '0;
    exp_imag = '0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_real = '0;
    in_imag = '0;
    reorder_done = 1'b0;
    cycle();
    chk_reset_outputs("por");
    reset = 1'b0;
    cycle();

    // Ramp frame: real=k, imag=-k
    for (int k = 0; k < NS; k++) push(DW'(k), DW'(-k), k == NS - 1);
    chk("ramp_slot7_real", int'(frame_real[7*DW +: DW]), 7);
    chk("ramp_slot15_imag", int'(frame_imag[15*DW +: DW]), 'hFFF1);
    chk("ramp_err", int'(frame_err), 0);
    issue_and_release(0);

    // Back-to-back: next frame offered immediately, done one cycle after start
    push_frame(NS - 1);
    issue_and_release(0);
    chk("b2b_count", int'(frame_count), 2);

    // Early in_last discards the partial frame
    for (int k = 0; k < 6; k++) push(DW'($urandom), DW'($urandom), k == 5);
    in_valid = 1'b0;
    chk("early_err", int'(frame_err), 1);
    chk("early_nostart", int'(start_reorder), 0);
    chk("early_ready", int'(in_ready), 1);
    cycle();
    chk("early_err_clear", int'(frame_err), 0);
    chk("early_nostart2", int'(start_reorder), 0);
    push_frame(NS - 1);
    issue_and_release(0);

    // Missing in_last on slot N-1: flagged but still issued
    push_frame(-1);
    chk("nolast_err", int'(frame_err), 1);
    issue_and_release(0);

    // Long downstream stall with in_valid active
    push_frame(NS - 1);
    issue_and_release(50);

    // Reset part way through a frame
    for (int k = 0; k < 9; k++) push(DW'($urandom), DW'($urandom), 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_fill");
    model_reset();
    cycle();
    reset = 1'b0;
    cycle();
    push_frame(NS - 1);
    issue_and_release(0);
    chk("rst_fill_count1", int'(frame_count), 1);

    // Reset while waiting for reorder_done
    push_frame(NS - 1);
    chk("rstw_start", int'(start_reorder), 1);
    in_valid = 1'b0;
    cycle();
    chk("rstw_in_wait", int'(in_ready), 0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_wait");
    model_reset();
    cycle();
    reset = 1'b0;
    repeat (3) cycle();
    chk("rstw_no_pulse", start_seen, m_starts);
    chk("rstw_ready", int'(in_ready), 1);
    push_frame(NS - 1);
    issue_and_release(0);
    chk("rstw_count1", int'(frame_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Upstream feeder for the FFT bit-reversal stage.
- Accepts a serial stream of complex samples over a valid/ready handshake and packs N samples into flattened real/imag frame buses.
- Pulses start_reorder for one cycle per complete frame, then holds the frame stable until reorder_done returns.
- Also checks frame alignment via in_last and counts issued frames.

Parameters:
- DATA_WIDTH, 16, bit width of each real/imag sample (signed two's complement).
- N, 16, samples per frame; power of two, ≥ 2.
- CNT_WIDTH, 16, width of the issued-frame counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  loader can accept a sample.
- in_real  in  DATA_WIDTH  sample real part, signed.
- in_imag  in  DATA_WIDTH  sample imag part, signed.
- in_last  in  1  marks the final sample of a frame.
- frame_real  out  N*DATA_WIDTH  packed real parts; slot k at bits [k*DATA_WIDTH +: DATA_WIDTH], slot 0 at LSBs.
- frame_imag  out  N*DATA_WIDTH  packed imag parts, same layout.
- start_reorder  out  1  one-cycle pulse; frame buses are valid.
- reorder_done  in  1  downstream completion pulse.
- frame_err  out  1  one-cycle pulse on alignment error.
- fill_count  out  log2(N)  slots filled in the current frame.
- frame_count  out  CNT_WIDTH  frames issued, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (reset, asynchronous, active-high; clock clk):
  - state=FILL; fill_count=0; frame_real/imag=0; start_reorder=0; frame_err=0; frame_count=0.
  - in_ready decodes state, so it reads 1 during reset, but no transfer is taken while reset is high.
  - Reset mid-frame or mid-WAIT drops the partial or issued frame with no further pulses.
- States:
  - FILL: in_ready=1.
  - ISSUE: in_ready=0; start_reorder=1.
  - WAIT: in_ready=0.
- A transfer is in_valid & in_ready at a rising edge.
- FILL, each transfer:
  - Write in_real/in_imag into slot fill_count, then fill_count+1.
  - Unwritten and stale slots keep their old values; the frame buses are only meaningful during ISSUE/WAIT.
- FILL, transfer at fill_count==N-1:
  - Next state ISSUE; fill_count returns to 0.
  - If in_last=0 on that sample: frame_err pulses on the next cycle, and the frame is still issued.
- FILL, transfer with in_last=1 at fill_count<N-1:
  - The sample is written, but the frame is discarded: fill_count=0, stay in FILL.
  - frame_err pulses on the next cycle.
- ISSUE: lasts exactly 1 cycle; frame_count increments; next state WAIT.
- WAIT:
  - frame_real/imag held bit-stable.
  - On reorder_done=1, go to FILL next cycle.
  - No timeout.
- reorder_done during FILL or ISSUE is ignored.
- Latency, with last sample accepted at edge t:
  - start_reorder high in cycle t+1.
  - Downstream done high in cycle t+2.
  - in_ready high again in cycle t+3.
  - Throughput: N+2 cycles per frame with a one-cycle-done downstream.
- All outputs are registered or pure state decode; there is no combinational path from in_valid to in_ready.
- No arithmetic on data; samples pass bit-exact with sign preserved.

Decomposition:
- Shared package fft_pkg holds:
  - DATA_WIDTH/N defaults.
  - INDEX_WIDTH = $clog2(N).
  - Loader state enum {FILL, ISSUE, WAIT}.
  - Slot-offset helper function (k*DATA_WIDTH).
- Single module; no natural sub-module.

Test Plan:
- Reset, then 16 samples real=k, imag=-k, in_last on k=15, in_valid held high:
  - slot k of frame_real = k; slot 15 of frame_imag = 16'hFFF1.
  - start_reorder pulses once, 1 cycle after the last edge; frame_count=1.
- Back-to-back frames, downstream done 1 cycle after start:
  - in_ready low for exactly 2 cycles between frames.
  - Second frame data correct; frame_count=2.
- in_last asserted on sample 5:
  - frame_err pulses once; no start_reorder; fill_count=0.
  - Next 16 samples form a correct frame.
- 16 samples, in_last=0 on sample 15:
  - frame_err pulse and start_reorder both occur; frame is issued.
- Hold reorder_done low for 50 cycles after start:
  - in_ready stays 0; frame buses unchanged; in_valid ignored.
  - Done pulse returns the loader to FILL.
- Assert reset after 9 samples or during WAIT:
  - All outputs zero immediately (asynchronous).
  - After release, a fresh 16-sample frame issues correctly with frame_count=1.
